// File: rtl/iob_2p_mem_fifo_ctrl_if.sv
// Handshake and memory-port bundle for the two-port memory FIFO controller.
// The slave modport is the controller. The master modport is the producer,
// the consumer and the attached two-port memory taken together.
interface iob_2p_mem_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  // write side
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  // read side
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  // two-port memory (asynchronous read)
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_data_out;
  // status
  logic [ADDR_W:0]   level;
  logic              full;
  logic              empty;

  modport slave (
    input  in_data, in_valid, out_ready, mem_data_out,
    output in_ready, out_data, out_valid,
    output mem_w_en, mem_w_addr, mem_data_in, mem_r_addr,
    output level, full, empty
  );

  modport master (
    output in_data, in_valid, out_ready, mem_data_out,
    input  in_ready, out_data, out_valid,
    input  mem_w_en, mem_w_addr, mem_data_in, mem_r_addr,
    input  level, full, empty
  );
endinterface

// File: rtl/iob_2p_mem_fifo_ctrl.sv
// FIFO controller for an external two-port memory with an asynchronous read port.
// Words are written straight into memory. They are prefetched from memory into
// a registered output stage, so the FIFO can hold up to D+1 words.
module iob_2p_mem_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  iob_2p_mem_fifo_ctrl_if.slave     bus
);

  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic full_s;
  logic push_s;
  logic load_s;

  // Handshake decode. It uses registered state only, so a load never frees a
  // slot within the same cycle. Reset blocks the memory write on its own edge.
  always_comb begin
    full_s = (mem_cnt_q == CNT_FULL);
    push_s = bus.in_valid && !full_s && !rst;
    load_s = (mem_cnt_q != CNT_ZERO) && (!out_valid_q || bus.out_ready);
  end

  // Next-state computation for the pointers, the memory count and the output stage.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    mem_cnt_d   = mem_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end

    if (load_s) begin
      rptr_d      = rptr_q + PTR_ONE;
      out_data_d  = bus.mem_data_out;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case ({push_s, load_s})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE;
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE;
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  // State registers with a synchronous reset that overrides any push or load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= PTR_ZERO;
      rptr_q      <= PTR_ZERO;
      mem_cnt_q   <= CNT_ZERO;
      out_data_q  <= DATA_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = !full_s;
  assign bus.mem_w_en    = push_s;
  assign bus.mem_w_addr  = wptr_q;
  assign bus.mem_data_in = bus.in_data;
  assign bus.mem_r_addr  = rptr_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.level       = mem_cnt_q + {{ADDR_W{1'b0}}, out_valid_q};
  assign bus.full        = full_s;
  assign bus.empty       = (mem_cnt_q == CNT_ZERO) && !out_valid_q;

endmodule

// File: tb/tb_iob_2p_mem_fifo_ctrl.sv
// Self-checking bench for iob_2p_mem_fifo_ctrl: a hand-computed vector table,
// then directed and random sequences scored against a small reference model.
module tb_iob_2p_mem_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk;
  logic rst;

  iob_2p_mem_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_2p_mem_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural two-port memory: synchronous write, asynchronous read
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_w_en) mem[bus.mem_w_addr] <= bus.mem_data_in;
  end
  assign bus.mem_data_out = mem[bus.mem_r_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  bit         m_ov = 1'b0;
  logic [7:0] m_od = 8'h00;
  logic [5:0] m_wptr = 6'd0;

  // One clock cycle: drive, check the combinational side, advance the model, check registered state.
  task automatic step(input bit r, input bit iv, input logic [7:0] d, input bit ordy, output bit acc);
    bit exp_rdy;
    bit exp_wen;
    bit ld;
    int lvl;
    @(negedge clk);
    rst = r; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
    #1;
    exp_rdy = (mq.size() != DEPTH);
    exp_wen = iv && exp_rdy && !r;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    chk("mem_w_en", {31'd0, bus.mem_w_en}, {31'd0, exp_wen});
    if (exp_wen) begin
      chk("mem_w_addr", {26'd0, bus.mem_w_addr}, {26'd0, m_wptr});
      chk("mem_data_in", {24'd0, bus.mem_data_in}, {24'd0, d});
    end
    acc = exp_wen;
    if (r) begin
      mq.delete(); m_ov = 1'b0; m_od = 8'h00; m_wptr = 6'd0;
    end else begin
      ld = (mq.size() != 0) && (!m_ov || ordy);
      if (ld) begin
        m_od = mq.pop_front(); m_ov = 1'b1;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (exp_wen) begin
        mq.push_back(d); m_wptr = m_wptr + 6'd1;
      end
    end
    @(posedge clk);
    #1;
    lvl = mq.size() + int'(m_ov);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
    chk("out_data", {24'd0, bus.out_data}, {24'd0, m_od});
    chk("level", {25'd0, bus.level}, lvl);
    chk("full", {31'd0, bus.full}, {31'd0, (mq.size() == DEPTH)});
    chk("empty", {31'd0, bus.empty}, {31'd0, (lvl == 0)});
    chk("level_max", {31'd0, (bus.level <= 7'd65)}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    bit         v_rst;
    bit         v_iv;
    logic [7:0] v_d;
    bit         v_ordy;
    bit         e_wen;
    logic [5:0] e_waddr;
    bit         e_rdy;
    bit         e_ov;
    logic [7:0] e_od;
    logic [6:0] e_lvl;
  } vec_t;

  vec_t tbl [14];

  initial begin
    bit acc;
    int dcnt;

    //           rst   iv    d      ordy  wen   waddr  rdy   ov    od     lvl
    tbl[0]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 8'h00, 7'd1};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 8'hA5, 7'd1};
    tbl[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 6'd1, 1'b1, 1'b1, 8'hA5, 7'd2};
    tbl[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 6'd2, 1'b1, 1'b1, 8'hA5, 7'd3};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 8'h11, 7'd2};
    tbl[5]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 6'd3, 1'b1, 1'b1, 8'h22, 7'd2};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 8'h33, 7'd1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 8'h33, 7'd0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 8'h33, 7'd0};
    tbl[9]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 6'd4, 1'b1, 1'b0, 8'h33, 7'd1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 8'h44, 7'd1};
    tbl[11] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 8'h00, 7'd0};
    tbl[12] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 8'h00, 7'd1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 8'h3C, 7'd1};

    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", {25'd0, bus.level}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tbl[i].v_rst; bus.in_valid = tbl[i].v_iv;
      bus.in_data = tbl[i].v_d; bus.out_ready = tbl[i].v_ordy;
      #1;
      chk($sformatf("vec%0d_wen", i), {31'd0, bus.mem_w_en}, {31'd0, tbl[i].e_wen});
      if (tbl[i].e_wen)
        chk($sformatf("vec%0d_waddr", i), {26'd0, bus.mem_w_addr}, {26'd0, tbl[i].e_waddr});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("vec%0d_out_data", i), {24'd0, bus.out_data}, {24'd0, tbl[i].e_od});
      chk($sformatf("vec%0d_level", i), {25'd0, bus.level}, {25'd0, tbl[i].e_lvl});
    end

    // fill to D+1 words with the consumer stalled; the 66th offer is ignored
    step(1'b1, 1'b0, 8'h00, 1'b0, acc);
    dcnt = 0;
    for (int i = 0; i < 66; i++) begin
      step(1'b0, 1'b1, dcnt[7:0], 1'b0, acc);
      if (acc) dcnt++;
    end
    chk("fill_accepted", dcnt, 32'd65);
    chk("fill_level", {25'd0, bus.level}, 32'd65);
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    chk("fill_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("fill_head", {24'd0, bus.out_data}, 32'd0);

    // streaming from full across several pointer wraps
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, dcnt[7:0], 1'b1, acc);
      if (acc) dcnt++;
    end
    chk("stream_pushes", dcnt, 32'd264);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      step(1'b0, ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 1) == 1), acc);
    end

    // reset mid-stream with 20 words held and a push offered on the reset edge
    step(1'b1, 1'b0, 8'h00, 1'b0, acc);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(100 + i), 1'b0, acc);
    chk("pre_reset_level", {25'd0, bus.level}, 32'd20);
    step(1'b1, 1'b1, 8'h77, 1'b0, acc);
    chk("post_reset_level", {25'd0, bus.level}, 32'd0);
    chk("post_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step(1'b0, 1'b1, 8'h3C, 1'b0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, acc);
    chk("first_after_reset_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("first_after_reset_data", {24'd0, bus.out_data}, 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iob_2p_mem_fifo_ctrl.md
IOB_2P_MEM_FIFO_CTRL -- requirements
Module: iob_2p_mem_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width; equals the attached memory's DATA_W.
REQ-002 SHALL have parameter ADDR_W, default 6, memory address width; depth D = 2**ADDR_W.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  DATA_W  write-side data.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  controller can accept a word.
REQ-009 out_data  output  DATA_W  registered read-side data.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 mem_w_en  output  1  write enable to the 2-port memory.
REQ-013 mem_w_addr  output  ADDR_W  memory write address.
REQ-014 mem_data_in  output  DATA_W  memory write data.
REQ-015 mem_r_addr  output  ADDR_W  memory read address; memory read is asynchronous.
REQ-016 mem_data_out  input  DATA_W  memory read data, combinational from mem_r_addr.
REQ-017 level  output  ADDR_W+1  total words held, memory words plus output register.
REQ-018 full  output  1  memory holds D words.
REQ-019 empty  output  1  level == 0.

Function
REQ-020 Pointers wptr and rptr SHALL be ADDR_W bits, wrapping from D-1 to 0; mem_cnt SHALL be ADDR_W+1 bits, range 0..D.
REQ-021 full SHALL be (mem_cnt == D); in_ready SHALL be !full, combinational from registered state only, never from in_valid.
REQ-022 A push SHALL occur when in_valid && in_ready; mem_w_en = push, mem_w_addr = wptr, mem_data_in = in_data, all combinational; wptr increments on the push edge.
REQ-023 mem_r_addr SHALL equal rptr at all times.
REQ-024 A load SHALL occur when mem_cnt != 0 (registered value) && (!out_valid || out_ready): out_data <= mem_data_out, out_valid <= 1, rptr increments.
REQ-025 When out_valid && out_ready with no load, out_valid SHALL clear to 0; out_data holds its value.
REQ-026 When out_valid && !out_ready, out_data and out_valid SHALL hold.
REQ-027 mem_cnt SHALL update +1 on push only, -1 on load only, unchanged on both or neither.
REQ-028 level SHALL equal mem_cnt + out_valid; maximum D+1.
REQ-029 Latency: a word pushed at edge k into an empty controller SHALL be loaded at edge k+1 and present with out_valid=1 from then on; no same-cycle bypass of memory write data.
REQ-030 Push and load in the same cycle SHALL both proceed, including when full (the load frees no slot until the next cycle; in_ready stays 0 that cycle).
REQ-031 Words SHALL leave in push order with no loss or duplication across pointer wrap.
REQ-032 in_valid while full SHALL be ignored: no write, no pointer or count change.

Reset
REQ-033 On rst=1 at a clock edge: wptr=0, rptr=0, mem_cnt=0, out_valid=0, out_data=0; hence level=0, empty=1, full=0, in_ready=1, mem_w_en=0 (given no push).
REQ-034 Reset SHALL take priority over a simultaneous push or load; memory contents are not cleared and are treated as invalid.

Verification
REQ-035 After reset, push 0xA5 with out_ready=0 -> mem_w_en=1, mem_w_addr=0; next edge out_valid=1, out_data=0xA5, level=1.
REQ-036 With out_ready=0 push 65 words (DATA_W=8, ADDR_W=6) -> the 65th is accepted only after 64 are in memory and 1 is in the output register; then full=1, in_ready=0, level=65; a 66th in_valid produces no write.
REQ-037 From full, hold in_valid=1 and out_ready=1 for 200 cycles with incrementing data -> push and load every cycle once in_ready=1, output sequence strictly increasing with no gaps, rptr wraps 63->0 correctly.
REQ-038 Random in_valid/out_ready (50% each), 10k cycles -> output stream matches scoreboard, level always equals pushed-minus-popped, never exceeds 65.
REQ-039 Assert rst mid-stream with level=20 and in_valid=1 -> next cycle level=0, out_valid=0, in_ready=1, no write on the reset edge; subsequent push 0x3C emerges as the first output.
